vga_framebuffer_scanout: RTL and testbench

- Receiving end of the pixel-write interface (color, x, y, writeEn) driven by the screen-drawing logic.
- Stores pixels in a 160x120x3-bit framebuffer.
- Scans the framebuffer out as 640x480@60 VGA timing with 4x pixel replication, and drives the video DAC signals.
- Provides a bulk-clear engine so the game controller can wipe the screen before a redraw.

---
 rtl/vga_framebuffer_scanout.sv | 172 +++++++++++++++++
 tb/tb_vga_framebuffer_scanout.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_framebuffer_scanout.sv
// 160x120x3 framebuffer with a bulk-clear engine, scanned out as 640x480@60 VGA with 4x
// pixel replication. Output pipeline is counters -> RAM read -> DAC registers (2 cycles).
module vga_framebuffer_scanout #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic [2:0]  BG_COLOR  = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] color,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic       writeEn,
  input  logic       clear_req,
  output logic       busy,
  output logic       frame_start,
  output logic [9:0] vga_r,
  output logic [9:0] vga_g,
  output logic [9:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank,
  output logic       vga_sync,
  output logic       VGA_clk
);

  localparam int unsigned FbDepth = 160 * 120;
  localparam logic [14:0] FbLast  = 15'(FbDepth - 1);

  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] HLast      = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] VLast      = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e      state_q, state_d;
  logic [14:0] caddr_q, caddr_d;
  logic [9:0]  hcnt_q, vcnt_q;

  logic [2:0]  mem [FbDepth];
  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [2:0]  mem_wdata;

  logic        wr_ok;
  logic [14:0] wr_addr;

  logic        visible, hs_n, vs_n, fs0;
  logic [14:0] rd_addr;
  logic [2:0]  rd_q;
  logic        vis1_q, hs1_q, vs1_q, fs1_q;

  assign VGA_clk  = ~clk;
  assign vga_sync = 1'b0;
  assign busy     = (state_q == StClear);

  // y*160 + x without a multiplier.
  assign wr_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
  assign wr_ok   = writeEn && (x <= 8'd159) && (y <= 7'd119);

  always_comb begin
    state_d   = state_q;
    caddr_d   = caddr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = color;
    unique case (state_q)
      StIdle: begin
        mem_we = wr_ok;
        if (clear_req) begin
          state_d = StClear;
          caddr_d = '0;
        end
      end
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = caddr_q;
        mem_wdata = BG_COLOR;
        caddr_d   = caddr_q + 15'd1;
        if (caddr_q == FbLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
    end
  end

  // Reset suppresses the write so an aborted clear stops exactly where it was.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (hcnt_q == HLast) begin
      hcnt_q <= '0;
      vcnt_q <= (vcnt_q == VLast) ? 10'd0 : vcnt_q + 10'd1;
    end else begin
      hcnt_q <= hcnt_q + 10'd1;
    end
  end

  always_comb begin
    visible = (hcnt_q < HVis) && (vcnt_q < VVis);
    hs_n    = !((hcnt_q >= HSyncStart) && (hcnt_q < HSyncEnd));
    vs_n    = !((vcnt_q >= VSyncStart) && (vcnt_q < VSyncEnd));
    fs0     = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    // Blanked positions read address 0 so the index never leaves the array.
    rd_addr = visible ? 15'({vcnt_q[8:2], 7'b0}) + 15'({vcnt_q[8:2], 5'b0}) + 15'(hcnt_q[9:2])
                      : 15'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vis1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      fs1_q  <= 1'b0;
    end else begin
      vis1_q <= visible;
      hs1_q  <= hs_n;
      vs1_q  <= vs_n;
      fs1_q  <= fs0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= (vis1_q && rd_q[2]) ? 10'h3FF : 10'h000;
      vga_g       <= (vis1_q && rd_q[1]) ? 10'h3FF : 10'h000;
      vga_b       <= (vis1_q && rd_q[0]) ? 10'h3FF : 10'h000;
      vga_hs      <= hs1_q;
      vga_vs      <= vs1_q;
      vga_blank   <= vis1_q;
      frame_start <= fs1_q;
    end
  end

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Directed bench for vga_framebuffer_scanout. The raster is shrunk to 24x12 (16x8 visible) so
// a frame is 288 cycles; off-screen framebuffer contents are observed through dut.mem.
module tb_vga_framebuffer_scanout;

  localparam int HV = 16, HF = 2, HS = 4, HB = 2, HT = HV + HF + HS + HB;
  localparam int VV = 8, VF = 1, VS = 2, VB = 1, VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int FB = 19200;

  logic       clk = 1'b0, rst = 1'b1, writeEn = 1'b0, clear_req = 1'b0;
  logic [2:0] color = 3'b000;
  logic [7:0] x = 8'd0;
  logic [6:0] y = 7'd0;
  logic       busy, frame_start, vga_hs, vga_vs, vga_blank, vga_sync, VGA_clk;
  logic [9:0] vga_r, vga_g, vga_b;

  int checks = 0, failures = 0;
  logic [2:0] model [FB];
  logic [9:0] cap_r [FRAME], cap_g [FRAME], cap_b [FRAME];
  logic       cap_hs [FRAME], cap_vs [FRAME], cap_bl [FRAME], cap_fs [FRAME];
  int         cap_wait;
  bit         cap_to;

  vga_framebuffer_scanout #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BG_COLOR(3'b000)
  ) dut (
    .clk(clk), .rst(rst), .color(color), .x(x), .y(y), .writeEn(writeEn),
    .clear_req(clear_req), .busy(busy), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank(vga_blank), .vga_sync(vga_sync), .VGA_clk(VGA_clk)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] exp_pix(input int i);
    int h, v;
    logic [2:0] c;
    h = i % HT;
    v = i / HT;
    c = (h < HV && v < VV) ? model[(v / 4) * 160 + h / 4] : 3'b000;
    return {{10{c[2]}}, {10{c[1]}}, {10{c[0]}}};
  endfunction

  task automatic write_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
    x = px; y = py; color = c; writeEn = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
  endtask

  // Sample 0 is the negedge showing frame_start; sample i displays counter position i.
  task automatic capture_frame();
    cap_wait = 0;
    cap_to = 1'b0;
    while (frame_start !== 1'b1 && cap_wait < 2 * FRAME) begin
      @(negedge clk);
      cap_wait++;
    end
    if (frame_start !== 1'b1) cap_to = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      cap_r[i] = vga_r; cap_g[i] = vga_g; cap_b[i] = vga_b;
      cap_hs[i] = vga_hs; cap_vs[i] = vga_vs; cap_bl[i] = vga_blank; cap_fs[i] = frame_start;
      if (i < FRAME - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, frame_start, vga_hs, vga_vs, vga_blank, vga_sync} !== 6'b001100) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 001100",
               {busy, frame_start, vga_hs, vga_vs, vga_blank, vga_sync});
    end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 30'd0) begin
      failures++;
      $display("FAIL reset_rgb: got %h/%h/%h want 0/0/0", vga_r, vga_g, vga_b);
    end
    #1;
    checks++;
    if (VGA_clk !== ~clk) begin
      failures++;
      $display("FAIL vga_clk: got %b want %b", VGA_clk, ~clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_timing();
    int hs_lo, vs_lo, bl_hi, fs_n;
    capture_frame();
    checks++;
    if (cap_to || cap_wait != 2) begin
      failures++;
      $display("FAIL first_frame_start: got delay %0d timeout %0b want 2", cap_wait, cap_to);
    end
    hs_lo = 0; vs_lo = 0; bl_hi = 0; fs_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      hs_lo += int'(!cap_hs[i]); vs_lo += int'(!cap_vs[i]);
      bl_hi += int'(cap_bl[i]);  fs_n += int'(cap_fs[i]);
    end
    checks++;
    if (hs_lo != VT * HS) begin
      failures++; $display("FAIL hs_low_count: got %0d want %0d", hs_lo, VT * HS);
    end
    checks++;
    if (vs_lo != VS * HT) begin
      failures++; $display("FAIL vs_low_count: got %0d want %0d", vs_lo, VS * HT);
    end
    checks++;
    if (bl_hi != HV * VV) begin
      failures++; $display("FAIL blank_count: got %0d want %0d", bl_hi, HV * VV);
    end
    checks++;
    if (fs_n != 1) begin
      failures++; $display("FAIL frame_start_count: got %0d want 1", fs_n);
    end
    checks++;
    if ({cap_hs[17], cap_hs[18], cap_hs[21], cap_hs[22]} !== 4'b1001) begin
      failures++;
      $display("FAIL hs_edges: got %b want 1001",
               {cap_hs[17], cap_hs[18], cap_hs[21], cap_hs[22]});
    end
    checks++;
    if ({cap_vs[215], cap_vs[216], cap_vs[263], cap_vs[264]} !== 4'b1001) begin
      failures++;
      $display("FAIL vs_edges: got %b want 1001",
               {cap_vs[215], cap_vs[216], cap_vs[263], cap_vs[264]});
    end
    checks++;
    if ({cap_bl[15], cap_bl[16], cap_bl[183], cap_bl[192]} !== 4'b1010) begin
      failures++;
      $display("FAIL blank_edges: got %b want 1010",
               {cap_bl[15], cap_bl[16], cap_bl[183], cap_bl[192]});
    end
    capture_frame();
    checks++;
    if (cap_to || cap_wait != 1) begin
      failures++;
      $display("FAIL frame_period: got %0d want %0d", FRAME - 1 + cap_wait, FRAME);
    end
  endtask

  task automatic test_fill_range();
    int bad, first;
    color = 3'b111;
    writeEn = 1'b1;
    for (int yy = 0; yy < 120; yy++) begin
      for (int xx = 0; xx < 160; xx++) begin
        x = 8'(xx); y = 7'(yy);
        @(negedge clk);
      end
    end
    for (int i = 0; i < FB; i++) model[i] = 3'b111;
    color = 3'b000; x = 8'd160; y = 7'd5;
    @(negedge clk);
    x = 8'd3; y = 7'd120;
    @(negedge clk);
    writeEn = 1'b0;
    bad = 0;
    for (int i = 0; i < FB; i++) if (dut.mem[i] !== 3'b111) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL fill_contents: got %0d wrong entries want 0", bad);
    end
    checks++;
    if ({dut.mem[960], dut.mem[155]} !== 6'b111111) begin
      failures++;
      $display("FAIL range_drop: got %b/%b want 111/111", dut.mem[960], dut.mem[155]);
    end
    capture_frame();
    bad = 0; first = -1;
    for (int i = 0; i < FRAME; i++)
      if ({cap_r[i], cap_g[i], cap_b[i]} !== exp_pix(i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (cap_to || bad != 0) begin
      failures++;
      $display("FAIL fill_frame: got %0d bad pixels (first %0d, timeout %0b) want 0",
               bad, first, cap_to);
    end
  endtask

  task automatic test_clear_reset();
    int bad_lo, bad_hi;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL clear_start_busy: got %b want 1", busy);
    end
    repeat (5000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, frame_start, vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b} !== {5'b00110, 30'd0})
    begin
      failures++;
      $display("FAIL abort_reset: got busy=%b fs=%b hs=%b vs=%b blank=%b rgb=%h/%h/%h want 0/0/1/1/0/0",
               busy, frame_start, vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b);
    end
    rst = 1'b0;
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < FB; i++) begin
      if (i < 5000 && dut.mem[i] !== 3'b000) bad_lo++;
      if (i >= 5000 && dut.mem[i] !== 3'b111) bad_hi++;
    end
    checks++;
    if (bad_lo != 0) begin
      failures++; $display("FAIL partial_cleared: got %0d uncleared below 5000 want 0", bad_lo);
    end
    checks++;
    if (bad_hi != 0) begin
      failures++; $display("FAIL partial_kept: got %0d changed at or above 5000 want 0", bad_hi);
    end
    for (int i = 0; i < 5000; i++) model[i] = 3'b000;
  endtask

  task automatic test_clear();
    int n, bad, first;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      n++;
      if (n == 100) begin x = 8'd10; y = 7'd10; color = 3'b010; writeEn = 1'b1; end
      if (n == 101) writeEn = 1'b0;
      if (n == 200) clear_req = 1'b1;
      if (n == 201) clear_req = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (n != FB) begin
      failures++; $display("FAIL busy_length: got %0d cycles want %0d", n, FB);
    end
    checks++;
    if (dut.mem[1610] !== 3'b000) begin
      failures++; $display("FAIL busy_write_drop: got %b want 000", dut.mem[1610]);
    end
    bad = 0;
    for (int i = 0; i < FB; i++) if (dut.mem[i] !== 3'b000) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL clear_contents: got %0d nonzero entries want 0", bad);
    end
    for (int i = 0; i < FB; i++) model[i] = 3'b000;
    capture_frame();
    bad = 0; first = -1;
    for (int i = 0; i < FRAME; i++)
      if ({cap_r[i], cap_g[i], cap_b[i]} !== exp_pix(i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (cap_to || bad != 0) begin
      failures++;
      $display("FAIL clear_frame: got %0d bad pixels (first %0d, timeout %0b) want 0",
               bad, first, cap_to);
    end
  endtask

  task automatic test_write_scan();
    int bad, first;
    write_px(8'd0, 7'd0, 3'b100);
    write_px(8'd159, 7'd119, 3'b011);
    model[0] = 3'b100;
    model[FB - 1] = 3'b011;
    checks++;
    if (dut.mem[FB - 1] !== 3'b011) begin
      failures++; $display("FAIL corner_write: got %b want 011", dut.mem[FB - 1]);
    end
    capture_frame();
    bad = 0; first = -1;
    for (int i = 0; i < FRAME; i++)
      if ({cap_r[i], cap_g[i], cap_b[i]} !== exp_pix(i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (cap_to || bad != 0) begin
      failures++;
      $display("FAIL write_frame: got %0d bad pixels (first %0d, timeout %0b) want 0",
               bad, first, cap_to);
    end
    checks++;
    if ({cap_r[0], cap_g[0], cap_b[0], cap_r[75], cap_g[75], cap_b[75]} !==
        {10'h3FF, 20'd0, 10'h3FF, 20'd0}) begin
      failures++;
      $display("FAIL red_block: got %h/%h/%h and %h/%h/%h want 3ff/0/0 twice",
               cap_r[0], cap_g[0], cap_b[0], cap_r[75], cap_g[75], cap_b[75]);
    end
    checks++;
    if ({cap_r[4], cap_r[96]} !== 20'd0) begin
      failures++; $display("FAIL red_block_edge: got %h/%h want 0/0", cap_r[4], cap_r[96]);
    end
  endtask

  task automatic test_collision();
    int n, bad, first;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      failures++; $display("FAIL collision_sync: got no frame_start want one");
    end
    // Scan counter runs two positions ahead of the outputs: at this point it reaches (2,0).
    @(negedge clk);
    @(negedge clk);
    write_px(8'd1, 7'd0, 3'b110);
    @(negedge clk);
    checks++;
    if ({vga_r, vga_g, vga_b} !== 30'd0) begin
      failures++; $display("FAIL collision_old: got %h/%h/%h want 0/0/0", vga_r, vga_g, vga_b);
    end
    @(negedge clk);
    checks++;
    if ({vga_r, vga_g, vga_b} !== {10'h3FF, 10'h3FF, 10'h000}) begin
      failures++;
      $display("FAIL collision_after: got %h/%h/%h want 3ff/3ff/0", vga_r, vga_g, vga_b);
    end
    model[1] = 3'b110;
    capture_frame();
    bad = 0; first = -1;
    for (int i = 0; i < FRAME; i++)
      if ({cap_r[i], cap_g[i], cap_b[i]} !== exp_pix(i)) begin
        if (bad == 0) first = i;
        bad++;
      end
    checks++;
    if (cap_to || bad != 0 || cap_g[4] !== 10'h3FF) begin
      failures++;
      $display("FAIL collision_next_frame: got %0d bad pixels (first %0d, g4=%h) want 0",
               bad, first, cap_g[4]);
    end
  endtask

  initial begin
    for (int i = 0; i < FB; i++) model[i] = 3'b000;
    test_reset();
    test_timing();
    test_fill_range();
    test_clear_reset();
    test_clear();
    test_write_scan();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
